// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD display path.
package bcd_pkg;

  localparam int unsigned NDIG  = 4;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned BCD_W = NDIG * DIG_W;
  localparam int unsigned SEG_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Active-low segment pattern, index 0 = a ... index 6 = g.
  typedef logic [0:SEG_W-1] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;

endpackage

// File: rtl/seg7_enc.sv
// Combinational BCD digit to active-low 7-segment encoder; codes 10..15 and
// an asserted blank both produce a dark display.
module seg7_enc
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] digit_i,
  input  logic             blank_i,
  output seg_t             seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Sequential double-dabble converter (one bit per clock) driving four
// registered HEX displays. Define BCD_BLANK_EN for leading-zero blanking.
module bcd_seq_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned IN = 10,
  parameter int unsigned S  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN-1:0]    bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd,
  output logic [0:S-1]     HEX0,
  output logic [0:S-1]     HEX1,
  output logic [0:S-1]     HEX2,
  output logic [0:S-1]     HEX3
);

  localparam int unsigned SR_W  = BCD_W + IN;
  localparam int unsigned CNT_W = $clog2(IN + 1);

  state_e             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               valid_q, valid_d;
  logic               busy_q, done_q;
  seg_t               hex_q [NDIG];
  seg_t               enc_seg [NDIG];
  logic [SR_W-1:0]    sr_adj, sr_shf;
  logic [NDIG-1:0]    zero_c, lead_c, blank_c;

  // Add-3 on every BCD nibble >= 5, then shift the whole register left.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (sr_q[IN + DIG_W*i +: DIG_W] >= 4'd5) begin
        sr_adj[IN + DIG_W*i +: DIG_W] = sr_q[IN + DIG_W*i +: DIG_W] + 4'd3;
      end
    end
    sr_shf = {sr_adj[SR_W-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {BCD_W'(0), bin};
          cnt_d   = CNT_W'(IN);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_shf;
        cnt_d = cnt_q - CNT_W'(1);
        // Last shift: capture the BCD field straight from the shifted value.
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = sr_shf[SR_W-1 -: BCD_W];
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-digit blanking; encoders see next-state digits so HEX moves with bcd.
  always_comb begin
    for (int i = 0; i < int'(NDIG); i++) begin
      zero_c[i] = (bcd_d[DIG_W*i +: DIG_W] == 4'd0);
    end
`ifdef BCD_BLANK_EN
    lead_c[NDIG-1] = zero_c[NDIG-1];
    for (int i = int'(NDIG) - 2; i >= 1; i--) begin
      lead_c[i] = lead_c[i+1] & zero_c[i];
    end
    lead_c[0] = 1'b0;
`else
    lead_c = '0;
`endif
    blank_c = lead_c | {NDIG{~valid_d}};
  end

  for (genvar g = 0; g < int'(NDIG); g++) begin : g_enc
    seg7_enc u_enc (
      .digit_i (bcd_d[DIG_W*g +: DIG_W]),
      .blank_i (blank_c[g]),
      .seg_c   (enc_seg[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < int'(NDIG); i++) hex_q[i] <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      busy_q  <= (state_d == SHIFT);
      done_q  <= (state_d == DONE);
      for (int i = 0; i < int'(NDIG); i++) hex_q[i] <= enc_seg[i];
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];

endmodule
